i8088_bus_sequencer: RTL

- Sequences every 8088 bus cycle in the 100 MHz AXI_CLK domain.
- Synchronises the CPU strobes and latches the multiplexed address on ALE.
- Stretches the cycle with READY, issues one transaction on a simple memory/IO request port, and owns the AD7..0 output enable and the external buffer direction.
- Sits between the board pins and the AXI master bridge inside i8088_cpu.

---
 rtl/i8088_bus_sequencer.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/i8088_bus_sequencer.sv
`timescale 1ns/1ps
// i8088_bus_sequencer
//   Runs every 8088 bus cycle in the AXI_CLK domain. The asynchronous CPU
//   strobes are synchronised, the multiplexed address is latched on the
//   falling edge of ALE, READY stretches the CPU cycle until the single
//   memory/IO transaction on the request port completes, and the block owns
//   the AD7..0 output enable and the external buffer direction.
//
// Ports
//   AXI_CLK, RESET          clock, asynchronous active-high reset
//   A_19_8, AD_in           address/data pins (sampled)
//   AD_out, AD_enout        AD7..0 drive value and output enable
//   nRD, nWR, IO_nM, ALE    asynchronous CPU strobes
//   READY                   0 stretches the CPU cycle
//   dbus_DIR                external buffer direction, 1 = FPGA drives CPU
//   mem_req .. mem_wdata    request port towards the bridge
//   mem_ack, mem_rdata      one-cycle acknowledge with read data
//   bus_err                 one-cycle pulse on timeout or strobe conflict
//
// SYNC_STAGES must be >= 2, WR_SETTLE must be >= 1.
module i8088_bus_sequencer #(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned WR_SETTLE      = 3,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        AXI_CLK,
    input  logic        RESET,
    input  logic [11:0] A_19_8,
    input  logic [7:0]  AD_in,
    output logic [7:0]  AD_out,
    output logic        AD_enout,
    input  logic        nRD,
    input  logic        nWR,
    input  logic        IO_nM,
    input  logic        ALE,
    output logic        READY,
    output logic        dbus_DIR,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_io,
    output logic [19:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    output logic        bus_err
);

    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned WS_W = $clog2(WR_SETTLE + 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WR_SETTLE,
        S_RD_REQ,
        S_WR_REQ,
        S_RELEASE
    } state_t;

    state_t state;

    logic [SYNC_STAGES-1:0] ale_sr;
    logic [SYNC_STAGES-1:0] nrd_sr;
    logic [SYNC_STAGES-1:0] nwr_sr;
    logic [SYNC_STAGES-1:0] io_sr;
    logic                   ale_q;

    logic ale_s;
    logic nrd_s;
    logic nwr_s;
    logic io_s;

    logic [TO_W-1:0] to_cnt;
    logic [WS_W-1:0] settle_cnt;

    assign ale_s = ale_sr[SYNC_STAGES-1];
    assign nrd_s = nrd_sr[SYNC_STAGES-1];
    assign nwr_s = nwr_sr[SYNC_STAGES-1];
    assign io_s  = io_sr[SYNC_STAGES-1];

    // Strobe synchronisers; the active-low strobes reset to their idle level
    // so that leaving reset never looks like a CPU access.
    always_ff @(posedge AXI_CLK or posedge RESET) begin
        if (RESET) begin
            ale_sr <= '0;
            nrd_sr <= '1;
            nwr_sr <= '1;
            io_sr  <= '0;
            ale_q  <= 1'b0;
        end else begin
            ale_sr <= {ale_sr[SYNC_STAGES-2:0], ALE};
            nrd_sr <= {nrd_sr[SYNC_STAGES-2:0], nRD};
            nwr_sr <= {nwr_sr[SYNC_STAGES-2:0], nWR};
            io_sr  <= {io_sr[SYNC_STAGES-2:0], IO_nM};
            ale_q  <= ale_s;
        end
    end

    always_ff @(posedge AXI_CLK or posedge RESET) begin
        if (RESET) begin
            state      <= S_IDLE;
            READY      <= 1'b1;
            AD_enout   <= 1'b0;
            dbus_DIR   <= 1'b0;
            AD_out     <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_io     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            bus_err    <= 1'b0;
            to_cnt     <= '0;
            settle_cnt <= '0;
        end else begin
            bus_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (ale_s) begin
                        READY <= 1'b0;
                    end
                    if (ale_q && !ale_s) begin
                        mem_addr <= {A_19_8, AD_in};
                        mem_io   <= io_s;
                        state    <= S_ADDR;
                    end
                end

                S_ADDR: begin
                    if (!nrd_s && !nwr_s) begin
                        bus_err <= 1'b1;
                        READY   <= 1'b1;
                        state   <= S_RELEASE;
                    end else if (!nrd_s) begin
                        mem_req <= 1'b1;
                        mem_we  <= 1'b0;
                        to_cnt  <= '0;
                        state   <= S_RD_REQ;
                    end else if (!nwr_s) begin
                        settle_cnt <= '0;
                        state      <= S_WR_SETTLE;
                    end
                end

                S_WR_SETTLE: begin
                    if (settle_cnt == WS_W'(WR_SETTLE - 1)) begin
                        mem_wdata <= AD_in;
                        mem_we    <= 1'b1;
                        mem_req   <= 1'b1;
                        to_cnt    <= '0;
                        state     <= S_WR_REQ;
                    end else begin
                        settle_cnt <= settle_cnt + WS_W'(1);
                    end
                end

                // Ack is tested before the timeout so a simultaneous ack wins.
                S_RD_REQ: begin
                    if (mem_ack) begin
                        mem_req  <= 1'b0;
                        AD_out   <= mem_rdata;
                        AD_enout <= 1'b1;
                        dbus_DIR <= 1'b1;
                        READY    <= 1'b1;
                        state    <= S_RELEASE;
                    end else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        mem_req  <= 1'b0;
                        bus_err  <= 1'b1;
                        AD_out   <= 8'hFF;
                        AD_enout <= 1'b1;
                        dbus_DIR <= 1'b1;
                        READY    <= 1'b1;
                        state    <= S_RELEASE;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end

                S_WR_REQ: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        READY   <= 1'b1;
                        state   <= S_RELEASE;
                    end else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        mem_req <= 1'b0;
                        bus_err <= 1'b1;
                        READY   <= 1'b1;
                        state   <= S_RELEASE;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end

                S_RELEASE: begin
                    if (nrd_s && nwr_s) begin
                        AD_enout <= 1'b0;
                        dbus_DIR <= 1'b0;
                        state    <= S_IDLE;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
